// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller
// with registered CPU/memory handshakes and saturating hit/miss counters.
module cache_ctrl #(
  parameter int NUM_LINES = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cpu_read,
  input  logic             cpu_write,
  input  logic [7:0]       cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic             cpu_ready,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_hit,
  output logic             busy,
  output logic             mem_req,
  output logic             mem_we,
  output logic [7:0]       mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int IW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, FILL, WRITE, RESP
  } state_t;

  state_t state, state_nx;

  logic [NUM_LINES-1:0] valid;
  logic [7:0]           tag  [NUM_LINES];
  logic [31:0]          data [NUM_LINES];

  logic          op_rd;
  logic          hit_q;
  logic [7:0]    addr_q;
  logic [31:0]   wdata_q;
  logic [IW-1:0] idx;
  logic          hit;
  logic          req;

  assign req = cpu_read | cpu_write;
  assign idx = addr_q[IW-1:0];
  assign hit = valid[idx] && (tag[idx] == addr_q);

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (req) state_nx = LOOKUP;
      LOOKUP: begin
        if (!op_rd)   state_nx = WRITE;
        else if (hit) state_nx = RESP;
        else          state_nx = FILL;
      end
      FILL:   if (mem_ack) state_nx = RESP;
      WRITE:  if (mem_ack) state_nx = RESP;
      RESP:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      valid      <= '0;
      op_rd      <= 1'b0;
      hit_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cpu_ready  <= 1'b0;
      cpu_rdata  <= '0;
      cpu_hit    <= 1'b0;
      busy       <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state     <= state_nx;
      cpu_ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            op_rd   <= cpu_read;
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
            busy    <= 1'b1;
          end
        end
        LOOKUP: begin
          hit_q <= hit;
          if (op_rd && hit) begin
            cpu_ready <= 1'b1;
            cpu_rdata <= data[idx];
            cpu_hit   <= 1'b1;
            hit_count <= sat_inc(hit_count);
          end else begin
            mem_req   <= 1'b1;
            mem_we    <= !op_rd;
            mem_addr  <= addr_q;
            mem_wdata <= op_rd ? mem_wdata : wdata_q;
          end
        end
        FILL: begin
          if (mem_ack) begin
            valid[idx] <= 1'b1;
            mem_req    <= 1'b0;
            cpu_ready  <= 1'b1;
            cpu_rdata  <= mem_rdata;
            cpu_hit    <= 1'b0;
            miss_count <= sat_inc(miss_count);
          end
        end
        WRITE: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            cpu_ready <= 1'b1;
            cpu_hit   <= hit_q;
            if (hit_q) hit_count  <= sat_inc(hit_count);
            else       miss_count <= sat_inc(miss_count);
          end
        end
        RESP: busy <= 1'b0;
        default: ;
      endcase
    end
  end

  // Line storage needs no reset: valid bits gate every use.
  always_ff @(posedge clock) begin
    if (state == FILL && mem_ack) begin
      tag[idx]  <= addr_q;
      data[idx] <= mem_rdata;
    end else if (state == LOOKUP && !op_rd && hit) begin
      data[idx] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench for cache_ctrl: directed requests push expected
// responses and memory ops; negedge monitors pop and compare.
module tb_cache_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_read = 1'b0;
  logic        cpu_write = 1'b0;
  logic [7:0]  cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        cpu_hit;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [7:0]  hit_count;
  logic [7:0]  miss_count;

  cache_ctrl #(.NUM_LINES(4), .CNT_W(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .cpu_hit(cpu_hit), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        hit;
    logic [31:0] rdata;
    logic        chk_rd;
    int          lat;
  } resp_t;

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } mop_t;

  resp_t rq[$];
  mop_t  mq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc = 0;
  int ready_seen = 0;
  int mlat = 3;
  int eh = 0;
  int em = 0;
  logic [31:0] mem_val = '0;

  always @(posedge clock) cyc++;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // response monitor
  always @(negedge clock) begin
    if (reset_n && cpu_ready) begin
      ready_seen++;
      if (rq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got cpu_ready=1 expected 0");
      end else begin
        resp_t e;
        e = rq.pop_front();
        chk("cpu_hit", 32'(cpu_hit), 32'(e.hit));
        if (e.chk_rd) chk("cpu_rdata", cpu_rdata, e.rdata);
        chk("latency", 32'(cyc - acc), 32'(e.lat));
      end
    end
  end

  // memory responder and memory-op monitor
  int   mcnt = 0;
  logic mprev = 1'b0;
  logic chk_drop = 1'b0;

  always @(negedge clock) begin
    if (!reset_n) begin
      mcnt     = 0;
      mem_ack  = 1'b0;
      mprev    = 1'b0;
      chk_drop = 1'b0;
    end else begin
      if (chk_drop) begin
        chk("mem_req_drop", 32'(mem_req), 32'd0);
        chk_drop = 1'b0;
      end
      mem_ack = 1'b0;
      if (mem_req && !mprev) begin
        if (mq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_mem_req: got addr %h expected none",
                   mem_addr);
        end else begin
          mop_t m;
          m = mq.pop_front();
          chk("mem_we", 32'(mem_we), 32'(m.we));
          chk("mem_addr", 32'(mem_addr), 32'(m.addr));
          if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
        end
      end
      if (mem_req) begin
        mcnt++;
        if (mcnt == mlat) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_val;
          chk_drop  = 1'b1;
          mcnt      = 0;
        end
      end else begin
        mcnt = 0;
      end
      mprev = mem_req;
    end
  end

  task automatic do_req(input logic rd, input logic wr,
                        input logic [7:0] a, input logic [31:0] wd,
                        input logic exp_hit, input logic [31:0] exp_rd,
                        input logic [31:0] mv, input logic poke);
    int    r0;
    resp_t e;
    mop_t  m;
    r0       = ready_seen;
    e.hit    = exp_hit;
    e.rdata  = exp_rd;
    e.chk_rd = rd;
    e.lat    = mlat + 1;
    if (rd && exp_hit) begin
      e.lat = 1;
    end else begin
      m.we    = !rd;
      m.addr  = a;
      m.wdata = wd;
      mq.push_back(m);
      if (rd) e.rdata = mv;
    end
    rq.push_back(e);
    if (exp_hit) eh++;
    else         em++;
    mem_val = mv;
    @(negedge clock);
    cpu_read  = rd;
    cpu_write = wr;
    cpu_addr  = a;
    cpu_wdata = wd;
    @(posedge clock);
    #1;
    acc       = cyc;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    if (poke) begin
      @(negedge clock);
      cpu_read = 1'b1;
      cpu_addr = 8'h40;
      @(posedge clock);
      #1;
      cpu_read = 1'b0;
    end
    for (int i = 0; i < 60 && ready_seen == r0; i++) @(posedge clock);
    chk("completion", 32'(ready_seen != r0), 32'd1);
    @(negedge clock);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("hit_count", 32'(hit_count), 32'(eh));
    chk("miss_count", 32'(miss_count), 32'(em));
  endtask

  initial begin
    mop_t m;
    repeat (2) @(negedge clock);
    chk("rst_ready", 32'(cpu_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_counts", {16'd0, hit_count, miss_count}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    do_req(1, 0, 8'h12, 0, 0, 0, 32'hDEADBEEF, 0);
    do_req(1, 0, 8'h12, 0, 1, 32'hDEADBEEF, 0, 0);
    do_req(0, 1, 8'h12, 32'h1, 1, 0, 0, 0);
    do_req(1, 0, 8'h12, 0, 1, 32'h1, 0, 0);
    do_req(0, 1, 8'h40, 32'hA5, 0, 0, 0, 0);
    do_req(1, 0, 8'h40, 0, 0, 0, 32'h40404040, 0);
    do_req(1, 0, 8'h16, 0, 0, 0, 32'h16161616, 0);
    do_req(1, 0, 8'h12, 0, 0, 0, 32'h12121212, 0);
    do_req(1, 1, 8'h12, 32'hBAD, 1, 32'h12121212, 0, 1);
    repeat (10) @(negedge clock);

    // reset while a fill is outstanding
    m.we    = 1'b0;
    m.addr  = 8'h20;
    m.wdata = '0;
    mq.push_back(m);
    mlat = 20;
    @(negedge clock);
    cpu_read = 1'b1;
    cpu_addr = 8'h20;
    @(posedge clock);
    #1;
    cpu_read = 1'b0;
    for (int i = 0; i < 10 && !mem_req; i++) begin
      @(posedge clock);
      #1;
    end
    @(negedge clock);
    chk("fill_mem_req", 32'(mem_req), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_fill_mem_req", 32'(mem_req), 32'd0);
    chk("rst_fill_busy", 32'(busy), 32'd0);
    chk("rst_fill_counts", {16'd0, hit_count, miss_count}, 32'd0);
    chk("rst_fill_addr", 32'(mem_addr), 32'd0);
    eh = 0;
    em = 0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    mlat = 3;
    repeat (3) @(negedge clock);

    do_req(1, 0, 8'h12, 0, 0, 0, 32'hCAFEF00D, 0);
    repeat (5) @(negedge clock);
    chk("resp_queue_empty", 32'(rq.size()), 32'd0);
    chk("mem_queue_empty", 32'(mq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
